alu_operand_arbiter: RTL
========================

# alu_operand_arbiter

Round-robin arbiter sharing the ALU's single 34-bit operand path between two requesters (e.g. weight-fetch and activation-feedback streams in the autoencoder datapath). It grants one requester per cycle via valid/ready handshakes and drives the select of the 34-bit 2:1 operand mux. It registers the selected word into a one-entry output stage with its own valid/ready handshake. A burst limit bounds how long one requester can hold the path while the other waits.

## Interface
- DATA_W, 34, operand width
- MAX_BURST, 4, max consecutive grants to one requester while the other is valid (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has a word
- req0_data  in  DATA_W  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle when high with req0_valid
- req1_valid / req1_data / req1_ready  same as requester 0
- sel  out  1  operand-mux select; 0 = req0_data, 1 = req1_data
- out_valid  out  1  output stage holds a word
- out_data  out  DATA_W  registered selected word
- out_src  out  1  requester that produced out_data
- out_ready  in  1  downstream ALU accepts out_data

## Operation
- State: owner (1 bit), burst_cnt (0..MAX_BURST), output stage (out_valid, out_data, out_src).
- load = ~out_valid | out_ready.
- Grant g, combinational:
  - only reqX_valid → g = X;
  - both valid and burst_cnt < MAX_BURST → g = owner;
  - both valid and burst_cnt == MAX_BURST → g = ~owner;
  - neither valid → g = owner (no transfer).
- sel = g. reqX_ready = load & (g == X). At most one ready is high per cycle.
- Transfer when load and any valid:
  - out_data ← mux(sel);
  - out_src ← g;
  - out_valid ← 1;
  - if g == owner, burst_cnt ← min(burst_cnt+1, MAX_BURST);
  - else owner ← g and burst_cnt ← 1.
- No transfer and out_ready & out_valid → out_valid ← 0.
- No transfer: owner and burst_cnt hold, including idle cycles.
- Data is passed unmodified; no width change, no arithmetic on data.

## Timing
- Reset, async assert: out_valid=0, out_data=0, out_src=0, owner=0, burst_cnt=0. sel=0 and both readys=0 while rst_n is low.
- Reset deassertion is synchronous to clk. The first grant is on the first edge after release.
- Latency: accepted word appears on out_data/out_valid one cycle after its handshake.
- Throughput: one word/cycle with out_ready held high.
- Back-pressure (out_valid=1, out_ready=0):
  - both readys low;
  - out_data/out_src stable;
  - owner/burst_cnt frozen.
- Simultaneous out_ready and new accept: the new word replaces the old in the same edge, with no bubble.
- Reset mid-stream: the in-flight output word is dropped. The requester must re-present it, and arbitration restarts from owner=0.

## Structure
- Shared package: DATA_W default, MAX_BURST default, source encodings SRC_REQ0=1'b0 and SRC_REQ1=1'b1.
- One sub-module: instantiate the existing 34-bit 2:1 mux (mux_2_1_34) for the data select, driven by sel.
- Arbiter FSM/counter and output register are local to this block.

## Test plan
- Reset: hold rst_n=0 with random inputs → out_valid=0, out_data=0, sel=0, req0_ready=req1_ready=0. Assert rst_n asynchronously mid-cycle → outputs clear before the next edge.
- req0 only: words 0x1, 0x2, 0x3 with out_ready=1 → out_data 0x1, 0x2, 0x3 on consecutive cycles, one cycle after each accept, out_src=0.
- Both valid continuously, MAX_BURST=4, out_ready=1 → grant sequence 0,0,0,0,1,1,1,1,0,…, with exactly one ready high per cycle.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1 and both requesters valid → out_data stable, both readys low. Release → the next word is accepted the same cycle.
- req1 alone after a req0 burst of 2 → immediate grant to req1, sel=1, out_src=1. A subsequent contention then favours req1 until burst_cnt reaches 4.
- Reset during a req1 burst with out_valid=1 → out_valid drops. Post-reset contention grants req0 first.

Source files
------------

// File: rtl/alu_operand_arbiter_pkg.sv
// Shared definitions for the ALU operand arbiter: widths, burst limit default,
// requester encodings and the debug view of the arbitration state.
package alu_operand_arbiter_pkg;

    localparam int DATA_W            = 34;
    localparam int MAX_BURST_DEFAULT = 4;

    typedef enum logic {
        SRC_REQ0 = 1'b0,
        SRC_REQ1 = 1'b1
    } src_t;

    // Arbitration state exposed for checkers; burst_cnt is zero-extended.
    typedef struct packed {
        src_t       owner;
        logic [7:0] burst_cnt;
        src_t       grant;
    } arb_dbg_t;

    function automatic src_t other_src(input src_t s);
        return (s == SRC_REQ0) ? SRC_REQ1 : SRC_REQ0;
    endfunction

endpackage

// File: rtl/alu_operand_arbiter_if.sv
// Requester, operand-select and output-stage signals of the ALU operand arbiter.
// Handshakes: a word moves when valid and ready are both high at a rising edge;
// valid never waits on ready, and data is held stable while valid && !ready.
interface alu_operand_arbiter_if
    import alu_operand_arbiter_pkg::*;
#(
    parameter int W = DATA_W
);
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         sel;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_src;
    logic         out_ready;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, sel, out_valid, out_data, out_src
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, sel, out_valid, out_data, out_src
    );
endinterface

// File: rtl/mux_2_1_34.sv
// Fixed 34-bit 2:1 operand multiplexer; sel=0 picks a, sel=1 picks b.
module mux_2_1_34 (
    input  logic [33:0] a,
    input  logic [33:0] b,
    input  logic        sel,
    output logic [33:0] y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/alu_operand_arbiter.sv
// Round-robin arbiter with a burst limit sharing the ALU operand path between
// two requesters, followed by a one-entry registered output stage.
module alu_operand_arbiter
    import alu_operand_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_operand_arbiter_if.slave  bus,
    output arb_dbg_t              dbg
);
    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    src_t              owner_q, owner_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    src_t              out_src_q, out_src_d;

    src_t              grant;
    logic              sel;
    logic              load;
    logic              xfer;
    logic [DATA_W-1:0] mux_y;

    // Grant and handshake outputs; forced to requester 0 / not-ready during reset.
    always_comb begin
        grant = owner_q;
        if (bus.req0_valid && !bus.req1_valid) begin
            grant = SRC_REQ0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            grant = SRC_REQ1;
        end else if (bus.req0_valid && bus.req1_valid && burst_q == BURST_MAX) begin
            grant = other_src(owner_q);
        end
        if (!rst_n) begin
            grant = SRC_REQ0;
        end
        sel            = grant;
        load           = ~out_valid_q | bus.out_ready;
        xfer           = rst_n & load & (bus.req0_valid | bus.req1_valid);
        bus.req0_ready = rst_n & load & (grant == SRC_REQ0);
        bus.req1_ready = rst_n & load & (grant == SRC_REQ1);
    end

    mux_2_1_34 u_mux (
        .a   (bus.req0_data),
        .b   (bus.req1_data),
        .sel (sel),
        .y   (mux_y)
    );

    always_comb begin
        owner_d     = owner_q;
        burst_d     = burst_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_y;
            out_src_d   = grant;
            if (grant == owner_q) begin
                if (burst_q != BURST_MAX) begin
                    burst_d = burst_q + CNT_W'(1);
                end
            end else begin
                owner_d = grant;
                burst_d = CNT_W'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= SRC_REQ0;
            burst_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC_REQ0;
        end else begin
            owner_q     <= owner_d;
            burst_q     <= burst_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.sel       = sel;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

    assign dbg.owner     = owner_q;
    assign dbg.burst_cnt = 8'(burst_q);
    assign dbg.grant     = grant;

endmodule
